timing_sequencer: RTL
=====================

# timing_sequencer

Sequence counter and timing/opcode decoder for the basic computer's control unit. It produces the one-hot timing signals `T[5:0]` and the registered opcode decode `D[7:0]` consumed by the per-register control blocks, which drive their `LD`, `CLR` and `INC` from `T`/`D` products. It also holds the run flip-flop `S`, honours start/halt, and counts completed instructions.

## Interface
Parameters:
- `NUM_T`, default 6: number of timing states; the counter spans 0..NUM_T-1.
- `CNT_W`, default 16: width of the instruction counter.

Ports:
- `clk` input, 1: system clock; all state changes on the rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `start` input, 1: level-sampled; sets S.
- `halt` input, 1: level-sampled; clears S (driven by the HLT decode).
- `sc_clr` input, 1: end-of-instruction from the execute logic; clears SC.
- `ir` input, 16: instruction register contents; bit 15 = I, bits 14:12 = opcode.
- `T` output, NUM_T: one-hot timing signals, all zero while halted.
- `D` output, 8: registered one-hot opcode decode.
- `I` output, 1: registered indirect bit.
- `S` output, 1: run flip-flop.
- `timeout_err` output, 1: one-cycle pulse when SC wraps without `sc_clr`.
- `instr_cnt` output, CNT_W: completed-instruction count.

## Operation
- State: `SC` (ceil(log2 NUM_T) bits), `S`, `D` register, `I` register, `instr_cnt`, `timeout_err` register.
- `T = S ? onehot(SC) : 0`, combinational from registers. Exactly one bit of `T` is high while S=1.
- S update, in priority order:
  - `halt` & S: S←0, SC←0.
  - `start` & !S: S←1, SC←0.
  - otherwise S holds.
  - `start` and `halt` in the same cycle: halt wins; S is cleared, or stays 0.
- SC update while S=1 and no halt, in priority order:
  - `sc_clr`: SC←0, and `instr_cnt`←`instr_cnt`+1.
  - SC==NUM_T-1: SC←0 and `timeout_err`←1 for one cycle; `instr_cnt` does not change.
  - otherwise SC←SC+1.
- While S=0, SC stays 0 and `sc_clr` is ignored: no count, no error.
- Opcode capture: on the edge ending T2 (S=1, SC==2, no halt), `D`←onehot(`ir[14:12]`) and `I`←`ir[15]`. This happens regardless of `sc_clr` that cycle. `D` and `I` hold at all other times, including across halt.
- `sc_clr` in T0/T1 returns SC to 0 with no D/I update, and still increments `instr_cnt`.
- `instr_cnt` wraps modulo 2^CNT_W with no flag.
- Reset (async, any time, including mid-instruction): SC=0, S=0, T=0, D=8'h00, I=0, `timeout_err`=0, `instr_cnt`=0. The first edge after `rst` deasserts is evaluated normally.

## Timing
- `start` sampled high at edge k → S=1 and T=6'b000001 (T0) during cycle k+1. T1 appears at k+2, T2 at k+3.
- IR is loaded externally at the end of T1, so `ir` is valid during T2. `D` and `I` are valid from T3 onward: one cycle of latency from T2.
- `sc_clr` high during Tn → T0 in the next cycle, giving zero dead cycles between instructions.
- `halt` high during Tn → T=0 in the next cycle. A later `start` resumes at T0.
- `timeout_err` is asserted in the cycle immediately after the wrapping T5 cycle, coincident with the new T0.
- `instr_cnt` reflects an `sc_clr` in the cycle after it is sampled.

## Test plan
1. Reset with S=0, then pulse `start` for one cycle → T sequence 01, 02, 04 over three cycles. With `ir`=16'h9123 during T2: D=8'h02 and I=1 from T3. Raise `sc_clr` in T4 → T0 next cycle, `instr_cnt`=1.
2. Run with no `sc_clr` → T cycles T0..T5, then T0 with `timeout_err`=1 for exactly one cycle; `instr_cnt` stays 0.
3. `halt` during T3 → T=0 and S=0 next cycle; D is unchanged. Pulse `start` → T0 on the following cycle.
4. `start` and `halt` high together while S=0, then again while S=1 → S=0 after each edge and T=0.
5. Assert `rst` asynchronously mid-T4 with `instr_cnt`=5 and D=8'h40 → all outputs zero immediately, without waiting for a clock edge.
6. Preload `instr_cnt` to 16'hFFFF via a sequence of `sc_clr`s (or force it), then one more `sc_clr` → `instr_cnt`=0. Separately, `sc_clr` in T1 → T0 next cycle and D unchanged.

Source files
------------

// File: rtl/timing_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timing_sequencer_if : control inputs and timing/decode outputs of the sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
interface timing_sequencer_if #(
  parameter int NUM_T = 6,
  parameter int CNT_W = 16
);
  logic             start;
  logic             halt;
  logic             sc_clr;
  logic [15:0]      ir;
  logic [NUM_T-1:0] T;
  logic [7:0]       D;
  logic             I;
  logic             S;
  logic             timeout_err;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output start, halt, sc_clr, ir,
    input  T, D, I, S, timeout_err, instr_cnt
  );

  modport slave (
    input  start, halt, sc_clr, ir,
    output T, D, I, S, timeout_err, instr_cnt
  );
endinterface
`default_nettype wire

// File: rtl/timing_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timing_sequencer : sequence counter, run flip-flop, opcode decode, instr count
// Revision 1.0
// ---------------------------------------------------------------------------
module timing_sequencer #(
  parameter int NUM_T = 6,
  parameter int CNT_W = 16
) (
  input  wire                  clk,
  input  wire                  rst,
  timing_sequencer_if.slave    bus
);

  localparam int         SC_W      = (NUM_T > 1) ? $clog2(NUM_T) : 1;
  localparam [SC_W-1:0]  c_SC_LAST = SC_W'(NUM_T - 1);
  localparam [SC_W-1:0]  c_SC_T2   = SC_W'(2);

  logic [SC_W-1:0]  sc_q,   sc_d;
  logic             run_q,  run_d;
  logic [7:0]       op_q,   op_d;
  logic             ind_q,  ind_d;
  logic             tout_q, tout_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  // Address bits are not part of the decode.
  logic w_ir_unused;
  assign w_ir_unused = ^bus.ir[11:0];

  always_comb begin
    sc_d   = sc_q;
    run_d  = run_q;
    op_d   = op_q;
    ind_d  = ind_q;
    tout_d = 1'b0;
    cnt_d  = cnt_q;
    if (bus.halt && run_q) begin
      run_d = 1'b0;
      sc_d  = '0;
    end else if (bus.start && !bus.halt && !run_q) begin
      run_d = 1'b1;
      sc_d  = '0;
    end else if (run_q) begin
      // Opcode capture at the end of T2 is independent of sc_clr.
      if (sc_q == c_SC_T2) begin
        op_d  = 8'b1 << bus.ir[14:12];
        ind_d = bus.ir[15];
      end
      if (bus.sc_clr) begin
        sc_d  = '0;
        cnt_d = cnt_q + 1'b1;
      end else if (sc_q == c_SC_LAST) begin
        sc_d   = '0;
        tout_d = 1'b1;
      end else begin
        sc_d = sc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_q   <= '0;
      run_q  <= 1'b0;
      op_q   <= 8'h00;
      ind_q  <= 1'b0;
      tout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sc_q   <= sc_d;
      run_q  <= run_d;
      op_q   <= op_d;
      ind_q  <= ind_d;
      tout_q <= tout_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_T; k++) begin : g_tdec
    assign bus.T[k] = run_q && (sc_q == SC_W'(k));
  end

  assign bus.D           = op_q;
  assign bus.I           = ind_q;
  assign bus.S           = run_q;
  assign bus.timeout_err = tout_q;
  assign bus.instr_cnt   = cnt_q;

endmodule
`default_nettype wire
